// File: rtl/ctrl_cas_sched.sv
// ctrl_cas_sched: in-order multi-bank CAS scheduler with per-entry tRCD hold and tCCD/turnaround spacing.
// Optional stall counters are compiled in with `define CAS_PERF_CNT_EN.

package ctrl_cas_sched_pkg;
  typedef enum logic [2:0] {
    RD_R  = 3'b000,
    RDA_R = 3'b001,
    WR_R  = 3'b010,
    WRA_R = 3'b011
  } cas_req_e;
endpackage

module ctrl_cas_sched
  import ctrl_cas_sched_pkg::*;
#(
  parameter int unsigned NUM_BG       = 4,
  parameter int unsigned BANKS_PER_BG = 4,
  parameter int unsigned QDEPTH       = 8,
  parameter int unsigned TRCD         = 16,
  parameter int unsigned TCCD_S       = 4,
  parameter int unsigned TCCD_L       = 6,
  parameter int unsigned TWTR         = 8,
  parameter int unsigned CNT_W        = 8,
  localparam int unsigned BG_W = (NUM_BG > 1) ? $clog2(NUM_BG) : 1,
  localparam int unsigned BA_W = (BANKS_PER_BG > 1) ? $clog2(BANKS_PER_BG) : 1
) (
  input  logic             CK_t,
  input  logic             reset,
  input  logic             act_vld,
  input  logic             act_no,
  input  logic [BG_W-1:0]  act_bg,
  input  logic [BA_W-1:0]  act_ba,
  input  logic [2:0]       act_rw,
  output logic             act_rdy,
  input  logic [CNT_W-1:0] CL,
  input  logic [CNT_W-1:0] CWL,
  input  logic [CNT_W-1:0] AL,
  input  logic [CNT_W-1:0] BL,
  output logic             cas_vld,
  input  logic             cas_ack,
  output logic [2:0]       cas_req,
  output logic [BG_W-1:0]  cas_bg,
  output logic [BA_W-1:0]  cas_ba,
  output logic             q_full,
  output logic             q_empty,
  output logic             cas_idle
`ifdef CAS_PERF_CNT_EN
  ,
  output logic [15:0]      stall_rcd_cnt,
  output logic [15:0]      stall_gap_cnt,
  output logic [15:0]      stall_ack_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned PW1   = PTR_W + 1;
  localparam int unsigned GW    = CNT_W + 2;
  localparam int unsigned SW    = CNT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE} state_e;

  state_e state_q, state_d;

  logic [BG_W-1:0]  bg_q  [QDEPTH];
  logic [BG_W-1:0]  bg_d  [QDEPTH];
  logic [BA_W-1:0]  ba_q  [QDEPTH];
  logic [BA_W-1:0]  ba_d  [QDEPTH];
  logic [2:0]       rw_q  [QDEPTH];
  logic [2:0]       rw_d  [QDEPTH];
  logic [CNT_W-1:0] rcd_q [QDEPTH];
  logic [CNT_W-1:0] rcd_d [QDEPTH];

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, q_count;
  logic [CNT_W-1:0] since_q, since_d;
  logic             last_wr_q, last_wr_d;
  logic [BG_W-1:0]  last_bg_q, last_bg_d;
  logic [2:0]       cas_req_q, cas_req_d;
  logic [BG_W-1:0]  cas_bg_q, cas_bg_d;
  logic [BA_W-1:0]  cas_ba_q, cas_ba_d;

  logic             push, pop;
  logic [PTR_W-1:0] head_idx, tail_idx;
  logic             head_wr, rcd_ok, gap_met;
  logic [GW-1:0]    r_after_w, w_after_r, w_after_r_clamp;
  logic [CNT_W-1:0] gap;

  function automatic logic is_write(input logic [2:0] rw);
    return (rw == WR_R) || (rw == WRA_R);
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [GW-1:0] v);
    return (v[GW-1:CNT_W] != '0) ? '1 : v[CNT_W-1:0];
  endfunction

  assign head_idx = rd_ptr_q[PTR_W-1:0];
  assign tail_idx = wr_ptr_q[PTR_W-1:0];
  assign q_count  = wr_ptr_q - rd_ptr_q;
  assign q_empty  = (wr_ptr_q == rd_ptr_q);
  assign q_full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign cas_vld  = (state_q == S_ISSUE);
  assign pop      = cas_vld && cas_ack;
  // A slot freed by this cycle's pop is offered back at once, so a full queue still accepts on the ack cycle.
  assign act_rdy  = !q_full || pop;
  assign push     = act_vld && act_rdy;
  assign cas_idle = q_empty && !cas_vld;
  assign cas_req  = cas_req_q;
  assign cas_bg   = cas_bg_q;
  assign cas_ba   = cas_ba_q;

  always_comb begin
    r_after_w = {2'b00, CWL} + ({2'b00, BL} >> 1) + GW'(TWTR);
    w_after_r = {2'b00, CL} - {2'b00, AL} - {2'b00, CWL} + ({2'b00, BL} >> 1) + GW'(2);
    // The wrapped difference stays within signed GW range, so the MSB is its sign.
    if (w_after_r[GW-1] || (w_after_r < GW'(TCCD_S))) begin
      w_after_r_clamp = GW'(TCCD_S);
    end else begin
      w_after_r_clamp = w_after_r;
    end
    head_wr = is_write(rw_q[head_idx]);
    if (head_wr && !last_wr_q) begin
      gap = sat_cnt(w_after_r_clamp);
    end else if (!head_wr && last_wr_q) begin
      gap = sat_cnt(r_after_w);
    end else if (bg_q[head_idx] == last_bg_q) begin
      gap = CNT_W'(TCCD_L);
    end else begin
      gap = CNT_W'(TCCD_S);
    end
    rcd_ok  = (rcd_q[head_idx] == '0);
    // Issuing on the next edge puts the handshake one edge later still.
    gap_met = ({1'b0, since_q} + SW'(1)) >= {1'b0, gap};
  end

  always_comb begin
    bg_d     = bg_q;
    ba_d     = ba_q;
    rw_d     = rw_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      rcd_d[i] = (rcd_q[i] == '0) ? '0 : rcd_q[i] - CNT_W'(1);
    end
    if (push) begin
      bg_d[tail_idx]  = act_bg;
      ba_d[tail_idx]  = act_ba;
      rw_d[tail_idx]  = act_rw;
      rcd_d[tail_idx] = act_no ? '0 : CNT_W'(TRCD - 1);
      wr_ptr_d        = wr_ptr_q + PW1'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW1'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    cas_req_d = cas_req_q;
    cas_bg_d  = cas_bg_q;
    cas_ba_d  = cas_ba_q;
    last_wr_d = last_wr_q;
    last_bg_d = last_bg_q;
    since_d   = (since_q == '1) ? since_q : since_q + CNT_W'(1);
    unique case (state_q)
      S_IDLE: begin
        if (push || !q_empty) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (q_empty) begin
          state_d = S_IDLE;
        end else if (rcd_ok && gap_met) begin
          state_d   = S_ISSUE;
          cas_req_d = rw_q[head_idx];
          cas_bg_d  = bg_q[head_idx];
          cas_ba_d  = ba_q[head_idx];
        end
      end
      S_ISSUE: begin
        if (cas_ack) begin
          last_wr_d = is_write(cas_req_q);
          last_bg_d = cas_bg_q;
          since_d   = CNT_W'(1);
          state_d   = ((q_count > PW1'(1)) || push) ? S_WAIT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      since_q   <= '1;
      last_wr_q <= 1'b0;
      last_bg_q <= '0;
      cas_req_q <= '0;
      cas_bg_q  <= '0;
      cas_ba_q  <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        bg_q[i]  <= '0;
        ba_q[i]  <= '0;
        rw_q[i]  <= '0;
        rcd_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      since_q   <= since_d;
      last_wr_q <= last_wr_d;
      last_bg_q <= last_bg_d;
      cas_req_q <= cas_req_d;
      cas_bg_q  <= cas_bg_d;
      cas_ba_q  <= cas_ba_d;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        bg_q[i]  <= bg_d[i];
        ba_q[i]  <= ba_d[i];
        rw_q[i]  <= rw_d[i];
        rcd_q[i] <= rcd_d[i];
      end
    end
  end

`ifdef CAS_PERF_CNT_EN
  logic [15:0] stall_rcd_q, stall_rcd_d;
  logic [15:0] stall_gap_q, stall_gap_d;
  logic [15:0] stall_ack_q, stall_ack_d;

  always_comb begin
    stall_rcd_d = stall_rcd_q;
    stall_gap_d = stall_gap_q;
    stall_ack_d = stall_ack_q;
    if ((state_q == S_WAIT) && !q_empty && !rcd_ok && (stall_rcd_q != '1)) begin
      stall_rcd_d = stall_rcd_q + 16'd1;
    end
    if ((state_q == S_WAIT) && !q_empty && rcd_ok && !gap_met && (stall_gap_q != '1)) begin
      stall_gap_d = stall_gap_q + 16'd1;
    end
    if ((state_q == S_ISSUE) && !cas_ack && (stall_ack_q != '1)) begin
      stall_ack_d = stall_ack_q + 16'd1;
    end
  end

  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      stall_rcd_q <= '0;
      stall_gap_q <= '0;
      stall_ack_q <= '0;
    end else begin
      stall_rcd_q <= stall_rcd_d;
      stall_gap_q <= stall_gap_d;
      stall_ack_q <= stall_ack_d;
    end
  end

  assign stall_rcd_cnt = stall_rcd_q;
  assign stall_gap_cnt = stall_gap_q;
  assign stall_ack_cnt = stall_ack_q;
`endif

endmodule
